npm_toggle_cal_executor: RTL and testbench
==========================================

Name: npm_toggle_cal_executor

Overview:
- Primitive-manager stage directly downstream of the BNC command generators. It consumes the CAL-issue trigger (PCommand bit 3), NumOfData, CASelect and CAData.
- It buffers the command/address byte stream, then drives CE#, CLE, ALE, WE# and DQ to the NAND interface with programmable WE# timing.
- It reports ready and last-step status back to the generator through the PM_Ready bit 3 and PM_LastStep bit 3 lanes.

Parameters:
- NumberOfWays, 4, number of chip-enable ways.
- BufferDepth, 8, CA byte buffer entries; power of two, minimum 2.
- WELowCycles, 2, WE# low time per byte, in clocks; minimum 1.
- WEHighCycles, 2, WE# high time after each byte, in clocks; minimum 1.

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  CAL trigger level (PCommand[3]); sampled only when oReady=1
- iTargetWay  in  NumberOfWays  one-hot way select; latched on accept
- iNumOfData  in  16  byte count minus one; latched on accept
- iCASelect  in  1  0 = command byte (CLE), 1 = address byte (ALE); sampled with each byte
- iCAData  in  8  CA byte; sampled during Capture
- oReady  out  1  high only in Idle
- oLastStep  out  1  one-cycle pulse at completion
- oPO_ChipEnable  out  NumberOfWays  active-low CE#
- oPO_CLE  out  1  command latch enable
- oPO_ALE  out  1  address latch enable
- oPO_WriteEnable  out  1  active-low WE#
- oPO_DQ  out  8  data bus

Behaviour:
- Reset (synchronous, takes priority, including mid-operation): the next edge goes to Idle and clears the buffer, counters and latched way.
  - Outputs after reset: oReady=1, oLastStep=0, oPO_ChipEnable all ones, CLE=0, ALE=0, WE#=1, DQ=0.
  - All outputs are registered except oReady, which decodes the state.
- States: Idle, Capture, Setup, WELow, WEHigh, Done.
- Idle:
  - iStart=1 is accepted: latch iTargetWay, and set Count = min(iNumOfData, BufferDepth-1) + 1. Go to Capture.
  - iStart while not Idle is ignored and is not queued.
- Capture:
  - Byte k (k = 0..Count-1) is taken as {iCASelect, iCAData} on the k-th cycle after the accept cycle, one per clock into buffer entry k.
  - The state lasts exactly Count cycles.
  - If iNumOfData >= BufferDepth, the state lasts BufferDepth cycles and bytes beyond the buffer are discarded.
  - Then go to Setup with index i=0.
- Setup (1 cycle):
  - CE# = ~TargetWay.
  - DQ = buf[i].data; CLE = ~buf[i].sel; ALE = buf[i].sel; WE# = 1.
- WELow: WE# = 0 for WELowCycles cycles; DQ, CLE and ALE held.
- WEHigh:
  - WE# = 1 for WEHighCycles cycles, giving the NAND latch edge.
  - Then, if i == Count-1, go to Done; otherwise i++ and go to Setup.
- CE# stays asserted from the first Setup through Done.
- Done (1 cycle): oLastStep=1, CLE=ALE=0, DQ=0. The next cycle is Idle with CE# all ones.
- Latency: accept-to-oLastStep = Count + Count*(1 + WELowCycles + WEHighCycles) + 1 cycles. With defaults and 1 byte this is 7.
- Counters: the WE# timer is wide enough for max(WELowCycles, WEHighCycles). The index has log2(BufferDepth) bits and does not wrap because Count <= BufferDepth.
- iNumOfData=0 means one byte; 0xFFFF is clamped to BufferDepth.
- Byte inputs sampled outside Capture are ignored.

Test Plan:
- Single command: iStart with NumOfData=0, CASelect=0, CAData=0x70, way 4'b0010.
  - Required: CE# = 4'b1101; CLE=1, ALE=0, DQ=0x70; one WE# low pulse of 2 cycles.
  - oLastStep pulses exactly 7 cycles after accept; oReady returns the following cycle.
- Mixed CA sequence: NumOfData=2, bytes {0,0x00}, {1,0x12}, {1,0x34}.
  - Required: three WE# pulses in order; CLE on byte 0, ALE on bytes 1–2; DQ values match.
  - oLastStep at cycle 3 + 3*5 + 1 = 19 after accept.
- Overflow clamp: NumOfData=20 with BufferDepth=8.
  - Required: exactly 8 WE# pulses carrying the first 8 bytes.
  - oLastStep at cycle 8 + 40 + 1 = 49.
- Busy start: pulse iStart again during WELow.
  - Required: no second accept, oReady=0 until Done completes, a single oLastStep.
- Reset mid-operation: assert iReset during WEHigh of byte 1.
  - Required: next edge gives WE#=1, CE# all ones, CLE=ALE=0, oReady=1, oLastStep=0.
  - A new iStart after reset completes normally.
- Timing parameters: instantiate WELowCycles=3, WEHighCycles=1 with 1 byte.
  - Required: WE# low for exactly 3 cycles, high for 1, oLastStep at cycle 1 + 5 + 1 = 7.

Source files
------------

// File: rtl/npm_toggle_cal_executor_if.sv
// Command-side handshake plus NAND pin bundle for the CAL executor.
interface npm_toggle_cal_executor_if #(parameter int NumberOfWays = 4);
  logic                    iStart;
  logic [NumberOfWays-1:0] iTargetWay;
  logic [15:0]             iNumOfData;
  logic                    iCASelect;
  logic [7:0]              iCAData;
  logic                    oReady;
  logic                    oLastStep;
  logic [NumberOfWays-1:0] oPO_ChipEnable;
  logic                    oPO_CLE;
  logic                    oPO_ALE;
  logic                    oPO_WriteEnable;
  logic [7:0]              oPO_DQ;

  modport slave (
    input  iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
    output oReady, oLastStep, oPO_ChipEnable, oPO_CLE, oPO_ALE, oPO_WriteEnable, oPO_DQ
  );

  modport master (
    output iStart, iTargetWay, iNumOfData, iCASelect, iCAData,
    input  oReady, oLastStep, oPO_ChipEnable, oPO_CLE, oPO_ALE, oPO_WriteEnable, oPO_DQ
  );
endinterface

// File: rtl/npm_toggle_cal_executor.sv
// CAL executor: buffers a CA byte burst, then replays it onto the NAND pins
// with programmable WE# low/high timing. Pin outputs are registered from the
// next-state decode so they change exactly when the state does.
module npm_toggle_cal_executor #(
  parameter int NumberOfWays = 4,
  parameter int BufferDepth  = 8,
  parameter int WELowCycles  = 2,
  parameter int WEHighCycles = 2
) (
  input logic iSystemClock,
  input logic iReset,
  npm_toggle_cal_executor_if.slave bus
);
  localparam int IdxW     = $clog2(BufferDepth);
  localparam int TimerMax = (WELowCycles > WEHighCycles) ? WELowCycles : WEHighCycles;
  localparam int TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  typedef enum logic [2:0] {Idle, Capture, Setup, WELow, WEHigh, Done} state_t;
  typedef struct packed {
    logic       sel;
    logic [7:0] data;
  } caByte_t;

  state_t                  state, nextState;
  caByte_t                 caBuf [BufferDepth];
  logic [NumberOfWays-1:0] wayReg, nextWay;
  logic [IdxW-1:0]         lastIdx, nextLastIdx, capIdx, nextCapIdx, byteIdx, nextByteIdx, incIdx;
  logic [TimerW-1:0]       timer, nextTimer;
  logic                    bufWrite;
  caByte_t                 inByte, loadByte;

  logic [NumberOfWays-1:0] ceReg, ceNext;
  logic                    cleReg, cleNext, aleReg, aleNext, weReg, weNext, lastReg, lastNext;
  logic [7:0]              dqReg, dqNext;

  assign inByte = '{sel: bus.iCASelect, data: bus.iCAData};
  assign incIdx = byteIdx + 1'b1;

  assign bus.oReady          = (state == Idle);
  assign bus.oLastStep       = lastReg;
  assign bus.oPO_ChipEnable  = ceReg;
  assign bus.oPO_CLE         = cleReg;
  assign bus.oPO_ALE         = aleReg;
  assign bus.oPO_WriteEnable = weReg;
  assign bus.oPO_DQ          = dqReg;

  // Next-state, counter and pin decode; pins default to the idle pattern.
  always_comb begin
    nextState   = state;
    nextWay     = wayReg;
    nextLastIdx = lastIdx;
    nextCapIdx  = capIdx;
    nextByteIdx = byteIdx;
    nextTimer   = timer;
    bufWrite    = 1'b0;
    loadByte    = caBuf[incIdx];
    ceNext      = '1;
    cleNext     = 1'b0;
    aleNext     = 1'b0;
    weNext      = 1'b1;
    lastNext    = 1'b0;
    dqNext      = '0;
    case (state)
      Idle: begin
        if (bus.iStart) begin
          nextWay     = bus.iTargetWay;
          nextLastIdx = (bus.iNumOfData >= 16'(BufferDepth)) ? IdxW'(BufferDepth - 1)
                                                              : bus.iNumOfData[IdxW-1:0];
          nextCapIdx  = '0;
          nextState   = Capture;
        end
      end
      Capture: begin
        bufWrite = 1'b1;
        if (capIdx == lastIdx) begin
          // A one-byte burst is still being written this cycle, so bypass it.
          loadByte    = (capIdx == '0) ? inByte : caBuf[0];
          nextByteIdx = '0;
          nextState   = Setup;
          ceNext      = ~wayReg;
          cleNext     = ~loadByte.sel;
          aleNext     = loadByte.sel;
          dqNext      = loadByte.data;
        end else begin
          nextCapIdx = capIdx + 1'b1;
        end
      end
      Setup: begin
        nextState = WELow;
        nextTimer = '0;
        ceNext    = ~wayReg;
        cleNext   = cleReg;
        aleNext   = aleReg;
        dqNext    = dqReg;
        weNext    = 1'b0;
      end
      WELow: begin
        ceNext  = ~wayReg;
        cleNext = cleReg;
        aleNext = aleReg;
        dqNext  = dqReg;
        if (timer == TimerW'(WELowCycles - 1)) begin
          nextTimer = '0;
          nextState = WEHigh;
        end else begin
          nextTimer = timer + 1'b1;
          weNext    = 1'b0;
        end
      end
      WEHigh: begin
        ceNext = ~wayReg;
        if (timer != TimerW'(WEHighCycles - 1)) begin
          nextTimer = timer + 1'b1;
          cleNext   = cleReg;
          aleNext   = aleReg;
          dqNext    = dqReg;
        end else if (byteIdx == lastIdx) begin
          nextState = Done;
          lastNext  = 1'b1;
        end else begin
          nextByteIdx = incIdx;
          nextState   = Setup;
          cleNext     = ~loadByte.sel;
          aleNext     = loadByte.sel;
          dqNext      = loadByte.data;
        end
      end
      Done: nextState = Idle;
      default: nextState = Idle;
    endcase
  end

  // State, buffer and registered pin outputs; reset wins over everything.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state   <= Idle;
      wayReg  <= '0;
      lastIdx <= '0;
      capIdx  <= '0;
      byteIdx <= '0;
      timer   <= '0;
      for (int i = 0; i < BufferDepth; i++) caBuf[i] <= '0;
      ceReg   <= '1;
      cleReg  <= 1'b0;
      aleReg  <= 1'b0;
      weReg   <= 1'b1;
      lastReg <= 1'b0;
      dqReg   <= '0;
    end else begin
      state   <= nextState;
      wayReg  <= nextWay;
      lastIdx <= nextLastIdx;
      capIdx  <= nextCapIdx;
      byteIdx <= nextByteIdx;
      timer   <= nextTimer;
      if (bufWrite) caBuf[capIdx] <= inByte;
      ceReg   <= ceNext;
      cleReg  <= cleNext;
      aleReg  <= aleNext;
      weReg   <= weNext;
      lastReg <= lastNext;
      dqReg   <= dqNext;
    end
  end
endmodule

// File: tb/tb_npm_toggle_cal_executor.sv
// Bench: two executors (2/2 and 3/1 WE# timing) share one randomized stimulus
// stream; each is compared cycle by cycle to a trace expanded from the command.
module tb_npm_toggle_cal_executor;
  localparam int NW = 4;
  localparam int BD = 8;

  typedef struct packed {
    logic          ready;
    logic          last;
    logic [NW-1:0] ce;
    logic          cle;
    logic          ale;
    logic          we;
    logic [7:0]    dq;
  } pins_t;
  typedef pins_t trace_t[$];

  logic          iSystemClock = 1'b0;
  logic          iReset;
  logic          start;
  logic [NW-1:0] tgtWay;
  logic [15:0]   numOfData;
  logic          caSel;
  logic [7:0]    caData;

  logic          stimSel  [32];
  logic [7:0]    stimData [32];

  int nChecks = 0;
  int nPass   = 0;

  always #5 iSystemClock = ~iSystemClock;

  npm_toggle_cal_executor_if #(.NumberOfWays(NW)) busA ();
  npm_toggle_cal_executor_if #(.NumberOfWays(NW)) busB ();

  assign busA.iStart = start;      assign busB.iStart = start;
  assign busA.iTargetWay = tgtWay; assign busB.iTargetWay = tgtWay;
  assign busA.iNumOfData = numOfData; assign busB.iNumOfData = numOfData;
  assign busA.iCASelect = caSel;   assign busB.iCASelect = caSel;
  assign busA.iCAData = caData;    assign busB.iCAData = caData;

  npm_toggle_cal_executor #(.NumberOfWays(NW), .BufferDepth(BD), .WELowCycles(2), .WEHighCycles(2))
    dutA (.iSystemClock(iSystemClock), .iReset(iReset), .bus(busA));
  npm_toggle_cal_executor #(.NumberOfWays(NW), .BufferDepth(BD), .WELowCycles(3), .WEHighCycles(1))
    dutB (.iSystemClock(iSystemClock), .iReset(iReset), .bus(busB));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic pins_t idlePins();
    pins_t p;
    p = '0; p.ready = 1'b1; p.ce = '1; p.we = 1'b1;
    return p;
  endfunction

  function automatic pins_t obsA();
    return {busA.oReady, busA.oLastStep, busA.oPO_ChipEnable, busA.oPO_CLE,
            busA.oPO_ALE, busA.oPO_WriteEnable, busA.oPO_DQ};
  endfunction

  function automatic pins_t obsB();
    return {busB.oReady, busB.oLastStep, busB.oPO_ChipEnable, busB.oPO_CLE,
            busB.oPO_ALE, busB.oPO_WriteEnable, busB.oPO_DQ};
  endfunction

  // Expected pins for every cycle after the accept cycle, ending back in idle.
  function automatic trace_t buildTrace(int lo, int hi, logic [NW-1:0] way, int count);
    trace_t tr;
    pins_t  p;
    p = idlePins(); p.ready = 1'b0;
    for (int k = 0; k < count; k++) tr.push_back(p);
    for (int k = 0; k < count; k++) begin
      p = '0; p.ce = ~way; p.cle = ~stimSel[k]; p.ale = stimSel[k]; p.dq = stimData[k];
      p.we = 1'b1; tr.push_back(p);
      p.we = 1'b0; for (int j = 0; j < lo; j++) tr.push_back(p);
      p.we = 1'b1; for (int j = 0; j < hi; j++) tr.push_back(p);
    end
    p = '0; p.ce = ~way; p.we = 1'b1; p.last = 1'b1; tr.push_back(p);
    tr.push_back(idlePins());
    return tr;
  endfunction

  task automatic randStim();
    for (int k = 0; k < 32; k++) begin
      stimSel[k]  = 1'($urandom);
      stimData[k] = 8'($urandom);
    end
  endtask

  // One command from accept to idle; optional busy re-start or reset at cycle t.
  task automatic runCommand(input string name, input logic [NW-1:0] way, input logic [15:0] nod,
                            input int busyAt, input int resetAt);
    trace_t ta, tbx;
    int     count, len, lastAtA, lastAtB, pulsesA, pulsesB;
    bit     aborted;
    count = (nod >= 16'(BD)) ? BD : int'(nod) + 1;
    ta  = buildTrace(2, 2, way, count);
    tbx = buildTrace(3, 1, way, count);
    len = (ta.size() > tbx.size()) ? ta.size() : tbx.size();
    lastAtA = -1; lastAtB = -1; pulsesA = 0; pulsesB = 0; aborted = 0;
    start = 1'b1; tgtWay = way; numOfData = nod;
    caSel = 1'($urandom); caData = 8'($urandom);
    @(posedge iSystemClock); #1;
    start = 1'b0; tgtWay = NW'($urandom); numOfData = 16'($urandom);
    for (int t = 1; t <= len; t++) begin
      chk($sformatf("%s A t%0d", name, t), 32'(obsA()), 32'((t <= ta.size())  ? ta[t-1]  : idlePins()));
      chk($sformatf("%s B t%0d", name, t), 32'(obsB()), 32'((t <= tbx.size()) ? tbx[t-1] : idlePins()));
      if (busA.oLastStep) begin pulsesA++; if (lastAtA < 0) lastAtA = t; end
      if (busB.oLastStep) begin pulsesB++; if (lastAtB < 0) lastAtB = t; end
      caSel  = (t - 1 < 32) ? stimSel[t-1]  : 1'($urandom);
      caData = (t - 1 < 32) ? stimData[t-1] : 8'($urandom);
      start  = (t == busyAt);
      if (t == resetAt) begin
        iReset = 1'b1;
        @(posedge iSystemClock); #1;
        chk($sformatf("%s A post-reset", name), 32'(obsA()), 32'(idlePins()));
        chk($sformatf("%s B post-reset", name), 32'(obsB()), 32'(idlePins()));
        iReset = 1'b0;
        aborted = 1;
        break;
      end
      @(posedge iSystemClock); #1;
    end
    start = 1'b0;
    if (!aborted) begin
      chk($sformatf("%s A latency", name), 32'(lastAtA), 32'(count + count * (1 + 2 + 2) + 1));
      chk($sformatf("%s B latency", name), 32'(lastAtB), 32'(count + count * (1 + 3 + 1) + 1));
      chk($sformatf("%s A pulses", name), 32'(pulsesA), 32'd1);
      chk($sformatf("%s B pulses", name), 32'(pulsesB), 32'd1);
    end
  endtask

  initial begin
    iReset = 1'b1; start = 1'b0; tgtWay = '0; numOfData = '0; caSel = 1'b0; caData = '0;
    randStim();
    repeat (2) @(posedge iSystemClock);
    #1;
    chk("reset A", 32'(obsA()), 32'(idlePins()));
    chk("reset B", 32'(obsB()), 32'(idlePins()));
    iReset = 1'b0;
    @(posedge iSystemClock); #1;

    stimSel[0] = 1'b0; stimData[0] = 8'h70;
    runCommand("single", 4'b0010, 16'd0, -1, -1);

    randStim();
    stimSel[0] = 1'b0; stimData[0] = 8'h00;
    stimSel[1] = 1'b1; stimData[1] = 8'h12;
    stimSel[2] = 1'b1; stimData[2] = 8'h34;
    runCommand("mixed", 4'b0100, 16'd2, -1, -1);

    randStim();
    runCommand("overflow", 4'b1000, 16'd20, -1, -1);

    randStim();
    runCommand("busy", 4'b0001, 16'd0, 3, -1);

    randStim();
    runCommand("midreset", 4'b0010, 16'd2, -1, 12);
    randStim();
    runCommand("afterreset", 4'b0100, 16'd1, -1, -1);

    randStim();
    runCommand("clampmax", 4'b0001, 16'hFFFF, -1, -1);

    for (int n = 0; n < 6; n++) begin
      randStim();
      runCommand($sformatf("rand%0d", n), NW'(1 << $urandom_range(0, NW - 1)),
                 16'($urandom_range(0, 9)), -1, -1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
